// File: rtl/snake_engine.sv
// snake_engine: Snake game core, one move per slw_clk edge on a
// 2^COORD_W x 2^COORD_W grid.
// Ports:
//   slw_clk, reset (async, active-low)      : game clock and reset
//   up/down/left/right                      : direction requests (up > down > left > right)
//   pause                                   : hold snake in RUN
//   restart                                 : leave OVER and reload the initial game
//   snake                                   : flat body, segment i at [i*2W +: 2W] as {y,x}, head at 0
//   length                                  : live segment count
//   write_snake                             : one-cycle pulse when snake holds a new body
//   xfood/yfood                             : food cell
//   score                                   : food eaten, saturating at 255
//   game_over                               : high while in OVER
module snake_engine #(
    parameter int                   COORD_W   = 4,
    parameter int                   MAX_LEN   = 8,
    parameter int                   WRAP      = 0,
    parameter logic [2*COORD_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic                                 slw_clk,
    input  logic                                 reset,
    input  logic                                 up,
    input  logic                                 down,
    input  logic                                 left,
    input  logic                                 right,
    input  logic                                 pause,
    input  logic                                 restart,
    output logic [MAX_LEN*2*COORD_W-1:0]         snake,
    output logic [$clog2(MAX_LEN+1)-1:0]         length,
    output logic                                 write_snake,
    output logic [COORD_W-1:0]                   xfood,
    output logic [COORD_W-1:0]                   yfood,
    output logic [7:0]                           score,
    output logic                                 game_over
);

    localparam int CW2   = 2 * COORD_W;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {ST_RUN, ST_SEARCH, ST_OVER} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [COORD_W-1:0]     C_ONE   = COORD_W'(2'd1);
    localparam logic [COORD_W-1:0]     C_TWO   = COORD_W'(2'd2);
    localparam logic [COORD_W-1:0]     C_THREE = COORD_W'(2'd3);
    localparam logic [COORD_W-1:0]     C_MAX   = {COORD_W{1'b1}};
    localparam logic [LEN_W-1:0]       LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]       LEN_INIT = LEN_W'(2'd3);
    localparam logic [CW2-1:0]         LFSR_INIT = CW2'(1'b1);
    // Initial body: head {1,3}, then {1,2}, {1,1}; remaining segments zero.
    localparam logic [MAX_LEN*CW2-1:0] INIT_SNAKE =
        {{((MAX_LEN-3)*CW2){1'b0}}, C_ONE, C_ONE, C_ONE, C_TWO, C_ONE, C_THREE};

    // Galois LFSR step: shift right, fold the taps in when a one falls out.
    function automatic logic [CW2-1:0] lfsr_step(input logic [CW2-1:0] v);
        logic [CW2-1:0] n;
        n = v >> 1;
        if (v[0]) begin
            n = n ^ LFSR_TAPS;
        end else begin
            n = n;
        end
        return n;
    endfunction

    function automatic dir_t opposite(input dir_t d);
        dir_t o;
        case (d)
            DIR_UP:    o = DIR_DOWN;
            DIR_DOWN:  o = DIR_UP;
            DIR_LEFT:  o = DIR_RIGHT;
            DIR_RIGHT: o = DIR_LEFT;
            default:   o = DIR_LEFT;
        endcase
        return o;
    endfunction

    state_t                   state_r, state_s;
    dir_t                     dir_r, dir_s, req_dir_s, eff_dir_s;
    logic [MAX_LEN*CW2-1:0]   snake_r, snake_s, moved_s;
    logic [LEN_W-1:0]         length_r, length_s, grown_len_s;
    logic                     write_r, write_s;
    logic [COORD_W-1:0]       xfood_r, xfood_s, yfood_r, yfood_s;
    logic [7:0]               score_r, score_s;
    logic                     over_r, over_s;
    logic [CW2-1:0]           lfsr_r, lfsr_s;
    logic [COORD_W-1:0]       head_x_s, head_y_s, new_x_s, new_y_s;
    logic                     edge_s, wall_hit_s, eat_s, self_hit_s, cand_hit_s;

    // Direction resolution: priority pick first, then drop a reversal.
    always_comb begin
        req_dir_s = dir_r;
        if (up) begin
            req_dir_s = DIR_UP;
        end else if (down) begin
            req_dir_s = DIR_DOWN;
        end else if (left) begin
            req_dir_s = DIR_LEFT;
        end else if (right) begin
            req_dir_s = DIR_RIGHT;
        end else begin
            req_dir_s = dir_r;
        end
        if (req_dir_s == opposite(dir_r)) begin
            eff_dir_s = dir_r;
        end else begin
            eff_dir_s = req_dir_s;
        end
    end

    // New head, wall detection, eat, self collision and the shifted body.
    always_comb begin
        head_y_s = snake_r[CW2-1:COORD_W];
        head_x_s = snake_r[COORD_W-1:0];
        new_y_s  = head_y_s;
        new_x_s  = head_x_s;
        edge_s   = 1'b0;
        case (eff_dir_s)
            DIR_UP:    begin new_y_s = head_y_s - C_ONE; edge_s = (head_y_s == '0);    end
            DIR_DOWN:  begin new_y_s = head_y_s + C_ONE; edge_s = (head_y_s == C_MAX); end
            DIR_LEFT:  begin new_x_s = head_x_s - C_ONE; edge_s = (head_x_s == '0);    end
            DIR_RIGHT: begin new_x_s = head_x_s + C_ONE; edge_s = (head_x_s == C_MAX); end
            default:   begin new_x_s = head_x_s;         edge_s = 1'b0;                end
        endcase
        wall_hit_s = (WRAP == 0) && edge_s;
        eat_s      = ({new_y_s, new_x_s} == {yfood_r, xfood_r});
        if (eat_s && (length_r != LEN_MAX)) begin
            grown_len_s = length_r + LEN_W'(1'b1);
        end else begin
            grown_len_s = length_r;
        end
        // The tail vacates its cell on a plain move, so it only counts when eating.
        self_hit_s = 1'b0;
        cand_hit_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((i + 1 < int'(length_r)) || (eat_s && (i < int'(length_r)))) &&
                (snake_r[i*CW2 +: CW2] == {new_y_s, new_x_s})) begin
                self_hit_s = 1'b1;
            end else begin
                self_hit_s = self_hit_s;
            end
            if ((i < int'(length_r)) && (snake_r[i*CW2 +: CW2] == lfsr_r)) begin
                cand_hit_s = 1'b1;
            end else begin
                cand_hit_s = cand_hit_s;
            end
        end
        moved_s            = '0;
        moved_s[CW2-1:0]   = {new_y_s, new_x_s};
        for (int i = 1; i < MAX_LEN; i++) begin
            if (i < int'(grown_len_s)) begin
                moved_s[i*CW2 +: CW2] = snake_r[(i-1)*CW2 +: CW2];
            end else begin
                moved_s[i*CW2 +: CW2] = '0;
            end
        end
    end

    // Game FSM next-state and next-output logic.
    always_comb begin
        state_s  = state_r;
        dir_s    = dir_r;
        snake_s  = snake_r;
        length_s = length_r;
        write_s  = 1'b0;
        xfood_s  = xfood_r;
        yfood_s  = yfood_r;
        score_s  = score_r;
        lfsr_s   = lfsr_step(lfsr_r);
        case (state_r)
            ST_RUN: begin
                if (!pause) begin
                    dir_s = eff_dir_s;
                    if (wall_hit_s || self_hit_s) begin
                        state_s = ST_OVER;
                    end else begin
                        snake_s  = moved_s;
                        length_s = grown_len_s;
                        write_s  = 1'b1;
                        if (eat_s) begin
                            state_s = ST_SEARCH;
                            score_s = (score_r == 8'hFF) ? score_r : score_r + 8'd1;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SEARCH: begin
                if (!cand_hit_s) begin
                    yfood_s = lfsr_r[CW2-1:COORD_W];
                    xfood_s = lfsr_r[COORD_W-1:0];
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_SEARCH;
                end
            end
            ST_OVER: begin
                if (restart) begin
                    state_s  = ST_RUN;
                    dir_s    = DIR_RIGHT;
                    snake_s  = INIT_SNAKE;
                    length_s = LEN_INIT;
                    xfood_s  = C_THREE;
                    yfood_s  = C_THREE;
                    score_s  = 8'd0;
                    lfsr_s   = LFSR_INIT;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s  = ST_RUN;
                dir_s    = DIR_RIGHT;
                snake_s  = INIT_SNAKE;
                length_s = LEN_INIT;
                xfood_s  = C_THREE;
                yfood_s  = C_THREE;
                score_s  = 8'd0;
                lfsr_s   = LFSR_INIT;
            end
        endcase
        over_s = (state_s == ST_OVER);
    end

    // State and output registers.
    always_ff @(posedge slw_clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            dir_r    <= DIR_RIGHT;
            snake_r  <= INIT_SNAKE;
            length_r <= LEN_INIT;
            write_r  <= 1'b0;
            xfood_r  <= C_THREE;
            yfood_r  <= C_THREE;
            score_r  <= 8'd0;
            over_r   <= 1'b0;
            lfsr_r   <= LFSR_INIT;
        end else begin
            state_r  <= state_s;
            dir_r    <= dir_s;
            snake_r  <= snake_s;
            length_r <= length_s;
            write_r  <= write_s;
            xfood_r  <= xfood_s;
            yfood_r  <= yfood_s;
            score_r  <= score_s;
            over_r   <= over_s;
            lfsr_r   <= lfsr_s;
        end
    end

    assign snake       = snake_r;
    assign length      = length_r;
    assign write_snake = write_r;
    assign xfood       = xfood_r;
    assign yfood       = yfood_r;
    assign score       = score_r;
    assign game_over   = over_r;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a default instance (4-bit coords, 8 segments,
// walls end the game) and a wrapping instance with MAX_LEN=4 for wrap and
// length saturation.
module tb_snake_engine;

    logic        slw_clk = 1'b0;
    int          total = 0;
    int          bad   = 0;

    // Default instance signals.
    logic        reset, up, down, left, right, pause, restart;
    logic [63:0] snake;
    logic [3:0]  length;
    logic        write_snake, game_over;
    logic [3:0]  xfood, yfood;
    logic [7:0]  score;

    // Wrapping instance signals.
    logic        w_reset, w_up, w_down, w_left, w_right, w_pause, w_restart;
    logic [31:0] w_snake;
    logic [2:0]  w_length;
    logic        w_write, w_over;
    logic [3:0]  w_xfood, w_yfood;
    logic [7:0]  w_score;

    snake_engine dut (
        .slw_clk(slw_clk), .reset(reset), .up(up), .down(down), .left(left),
        .right(right), .pause(pause), .restart(restart), .snake(snake),
        .length(length), .write_snake(write_snake), .xfood(xfood), .yfood(yfood),
        .score(score), .game_over(game_over)
    );

    snake_engine #(.COORD_W(4), .MAX_LEN(4), .WRAP(1), .LFSR_TAPS(8'hB8)) dut_w (
        .slw_clk(slw_clk), .reset(w_reset), .up(w_up), .down(w_down), .left(w_left),
        .right(w_right), .pause(w_pause), .restart(w_restart), .snake(w_snake),
        .length(w_length), .write_snake(w_write), .xfood(w_xfood), .yfood(w_yfood),
        .score(w_score), .game_over(w_over)
    );

    always #5 slw_clk = ~slw_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slw_clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        pause = 1'b0; restart = 1'b0;
        w_reset = 1'b0; w_up = 1'b0; w_down = 1'b0; w_left = 1'b0; w_right = 1'b0;
        w_pause = 1'b0; w_restart = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_snake", 64'(snake), 64'h0000_0000_0011_1213);
        check("rst_len",   64'(length), 64'd3);
        check("rst_food",  64'({yfood, xfood}), 64'h33);
        check("rst_score", 64'(score), 64'd0);
        check("rst_write", 64'(write_snake), 64'd0);
        check("rst_over",  64'(game_over), 64'd0);

        // Four idle ticks: head walks right, one pulse per tick.
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("idle_head",  64'(snake[7:0]), 64'(8'h14 + 8'(k)));
            check("idle_write", 64'(write_snake), 64'd1);
            check("idle_len",   64'(length), 64'd3);
        end
        check("idle_body", 64'(snake), 64'h0000_0000_0015_1617);

        // Asynchronous reset between edges.
        reset = 1'b0;
        #1;
        check("async_snake", 64'(snake), 64'h0000_0000_0011_1213);
        check("async_write", 64'(write_snake), 64'd0);
        reset = 1'b1;

        // Down twice: eat at {3,3}, then one SEARCH cycle finds {5,12}.
        down = 1'b1;
        tick();
        check("down1_head", 64'(snake[7:0]), 64'h23);
        tick();
        check("eat_body",  64'(snake), 64'h0000_0000_1213_2333);
        check("eat_len",   64'(length), 64'd4);
        check("eat_score", 64'(score), 64'd1);
        check("eat_write", 64'(write_snake), 64'd1);
        check("eat_food_hold", 64'({yfood, xfood}), 64'h33);
        tick();
        check("search_food",  64'({yfood, xfood}), 64'h5C);
        check("search_write", 64'(write_snake), 64'd0);
        check("search_body",  64'(snake), 64'h0000_0000_1213_2333);
        down = 1'b0;

        // Tight loop with length 4: head re-enters the vacating tail cell.
        right = 1'b1;
        tick();
        check("loop_r", 64'(snake[7:0]), 64'h34);
        right = 1'b0; up = 1'b1;
        tick();
        check("loop_u", 64'(snake[7:0]), 64'h24);
        up = 1'b0; left = 1'b1;
        tick();
        check("loop_l_head", 64'(snake[7:0]), 64'h23);
        check("loop_l_over", 64'(game_over), 64'd0);
        left = 1'b0; down = 1'b1;
        tick();
        check("loop_d_body", 64'(snake), 64'h0000_0000_3424_2333);
        check("loop_d_over", 64'(game_over), 64'd0);
        check("loop_d_write", 64'(write_snake), 64'd1);
        down = 1'b0;

        // Reversal ignored; left+right resolves to left, which is a reversal.
        reset = 1'b0; #1; reset = 1'b1;
        left = 1'b1;
        tick();
        check("rev_head", 64'(snake[7:0]), 64'h14);
        right = 1'b1;
        tick();
        check("rev_prio_head", 64'(snake[7:0]), 64'h15);
        left = 1'b0; right = 1'b0;

        // Up+left picks up; second up hits the top wall.
        reset = 1'b0; #1; reset = 1'b1;
        up = 1'b1; left = 1'b1;
        tick();
        check("upleft_head", 64'(snake[7:0]), 64'h03);
        left = 1'b0;
        tick();
        check("wall_over",  64'(game_over), 64'd1);
        check("wall_write", 64'(write_snake), 64'd0);
        check("wall_body",  64'(snake), 64'h0000_0000_0012_1303);
        tick();
        check("over_frozen", 64'(snake), 64'h0000_0000_0012_1303);
        check("over_hold",   64'(game_over), 64'd1);
        up = 1'b0; restart = 1'b1;
        tick();
        check("restart_body", 64'(snake), 64'h0000_0000_0011_1213);
        check("restart_over", 64'(game_over), 64'd0);
        check("restart_len",  64'(length), 64'd3);
        restart = 1'b0;

        // Wrapping instance: 13 moves right wraps x from 15 to 0.
        w_reset = 1'b1;
        repeat (12) tick();
        check("w_edge_head", 64'(w_snake[7:0]), 64'h1F);
        tick();
        check("w_wrap_body",  64'(w_snake), 64'h001E_1F10);
        check("w_wrap_over",  64'(w_over), 64'd0);
        check("w_wrap_write", 64'(w_write), 64'd1);

        w_reset = 1'b0;
        #1;
        check("w_async_snake", 64'(w_snake), 64'h0011_1213);
        w_reset = 1'b1;

        // Grow to MAX_LEN=4, then eat the next food at saturation.
        w_down = 1'b1;
        tick();
        tick();
        check("w_eat1_body", 64'(w_snake), 64'h1213_2333);
        check("w_eat1_len",  64'(w_length), 64'd4);
        tick();
        check("w_food1", 64'({w_yfood, w_xfood}), 64'h5C);
        tick();
        tick();
        check("w_down_head", 64'(w_snake[7:0]), 64'h53);
        w_down = 1'b0; w_right = 1'b1;
        repeat (8) tick();
        check("w_pre_head",  64'(w_snake[7:0]), 64'h5B);
        check("w_pre_score", 64'(w_score), 64'd1);
        tick();
        check("w_sat_body",  64'(w_snake), 64'h595A_5B5C);
        check("w_sat_len",   64'(w_length), 64'd4);
        check("w_sat_score", 64'(w_score), 64'd2);
        check("w_sat_write", 64'(w_write), 64'd1);
        tick();
        check("w_food2",       64'({w_yfood, w_xfood}), 64'hAE);
        check("w_search_write", 64'(w_write), 64'd0);

        // Pause for three ticks: nothing moves, no pulses.
        w_pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("w_pause_body",  64'(w_snake), 64'h595A_5B5C);
            check("w_pause_write", 64'(w_write), 64'd0);
        end
        w_pause = 1'b0;
        tick();
        check("w_resume_head",  64'(w_snake[7:0]), 64'h5D);
        check("w_resume_write", 64'(w_write), 64'd1);
        w_right = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
